// File: rtl/llc_input_arbiter_pkg.sv
// llc_input_arbiter_pkg: shared types and constants for the LLC input arbiter.
package llc_input_arbiter_pkg;
  localparam int LLC_ARB_MAX_INFLIGHT = 4;
  localparam int LLC_ARB_SET_BITS = 9;
  typedef enum logic [1:0] {
    ARB_RST = 2'd0,
    ARB_RSP = 2'd1,
    ARB_REQ = 2'd2,
    ARB_DMA = 2'd3
  } llc_arb_src_t;
  typedef struct packed {
    logic                        valid;
    logic [LLC_ARB_SET_BITS-1:0] set;
    llc_arb_src_t                src;
  } llc_arb_entry_t;
endpackage

// File: rtl/llc_inflight_tracker.sv
// llc_inflight_tracker: in-order circular buffer of in-flight lookups with occupancy count,
// sticky underflow flag and set-hazard matching against req/dma entries.
module llc_inflight_tracker
  import llc_input_arbiter_pkg::*;
#(
  parameter int SET_BITS     = 9,
  parameter int MAX_INFLIGHT = LLC_ARB_MAX_INFLIGHT,
  parameter int CNT_BITS     = $clog2(MAX_INFLIGHT) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc_i,
  input  logic [SET_BITS-1:0] alloc_set_i,
  input  llc_arb_src_t        alloc_src_i,
  input  logic                retire_i,
  input  logic [SET_BITS-1:0] req_set_i,
  input  logic [SET_BITS-1:0] dma_set_i,
  output logic [CNT_BITS-1:0] cnt_o,
  output logic [CNT_BITS-1:0] cnt_eff_o,
  output logic                retire_err_o,
  output logic                req_hit_o,
  output logic                dma_hit_o
);
  localparam int PW = $clog2(MAX_INFLIGHT);
  logic [MAX_INFLIGHT-1:0] vld_q;
  logic [SET_BITS-1:0]     set_q [MAX_INFLIGHT];
  llc_arb_src_t            src_q [MAX_INFLIGHT];
  logic [PW-1:0]           wr_q, rd_q;
  logic [CNT_BITS-1:0]     cnt_q, cnt_d;
  logic                    err_q;
  logic                    ret_ok;
  logic [MAX_INFLIGHT-1:0] eff;
  // The entry retiring this cycle no longer blocks anything.
  always_comb begin
    ret_ok    = retire_i && cnt_q != '0;
    cnt_eff_o = cnt_q - CNT_BITS'(ret_ok);
    cnt_d     = cnt_eff_o + CNT_BITS'(alloc_i);
    eff       = vld_q;
    if (ret_ok) eff[rd_q] = 1'b0;
    req_hit_o = 1'b0;
    dma_hit_o = 1'b0;
    for (int i = 0; i < MAX_INFLIGHT; i++) begin
      req_hit_o |= eff[i] && (src_q[i] inside {ARB_REQ, ARB_DMA}) && set_q[i] == req_set_i;
      dma_hit_o |= eff[i] && (src_q[i] inside {ARB_REQ, ARB_DMA}) && set_q[i] == dma_set_i;
    end
  end
  // Allocation is applied after retirement so a full-buffer swap keeps the new entry valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (ret_ok) begin
        vld_q[rd_q] <= 1'b0;
        rd_q        <= rd_q + 1'b1;
      end
      if (alloc_i) begin
        vld_q[wr_q] <= 1'b1;
        set_q[wr_q] <= alloc_set_i;
        src_q[wr_q] <= alloc_src_i;
        wr_q        <= wr_q + 1'b1;
      end
      cnt_q <= cnt_d;
      if (retire_i && cnt_q == '0) err_q <= 1'b1;
    end
  end
  assign cnt_o        = cnt_q;
  assign retire_err_o = err_q;
endmodule

// File: rtl/llc_input_arbiter.sv
// llc_input_arbiter: fixed-priority (rst_tb > rsp > req/dma round-robin) scheduler into the set-lookup pipeline.
// Optional LLC_ARB_STATS_EN adds per-source grant counters and a hazard-stall counter.
module llc_input_arbiter
  import llc_input_arbiter_pkg::*;
#(
  parameter int SET_BITS     = 9,
  parameter int MAX_INFLIGHT = LLC_ARB_MAX_INFLIGHT,
  parameter int CNT_BITS     = $clog2(MAX_INFLIGHT) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rst_tb_valid,
  output logic                rst_tb_ready,
  input  logic                rsp_valid,
  output logic                rsp_ready,
  input  logic [SET_BITS-1:0] rsp_set,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [SET_BITS-1:0] req_set,
  input  logic                dma_valid,
  output logic                dma_ready,
  input  logic [SET_BITS-1:0] dma_set,
  output logic                grant_valid,
  input  logic                grant_ready,
  output logic [1:0]          grant_src,
  output logic [SET_BITS-1:0] grant_set,
  input  logic                retire_valid,
  output logic [CNT_BITS-1:0] inflight_cnt,
`ifdef LLC_ARB_STATS_EN
  input  logic [2:0]          stats_sel,
  output logic [31:0]         stats_data,
`endif
  output logic                retire_err
);
  logic                gv_q;
  llc_arb_src_t        src_q, win;
  logic [SET_BITS-1:0] set_q, win_set;
  logic                rr_q, rr_d;
  logic [CNT_BITS-1:0] cnt_eff;
  logic                req_hit, dma_hit;
  logic                load_ok, rst_el, req_el, dma_el, any_el, acc;
  llc_inflight_tracker #(
    .SET_BITS    (SET_BITS),
    .MAX_INFLIGHT(MAX_INFLIGHT),
    .CNT_BITS    (CNT_BITS)
  ) u_trk (
    .clk         (clk),
    .rst         (rst),
    .alloc_i     (acc),
    .alloc_set_i (win_set),
    .alloc_src_i (win),
    .retire_i    (retire_valid),
    .req_set_i   (req_set),
    .dma_set_i   (dma_set),
    .cnt_o       (inflight_cnt),
    .cnt_eff_o   (cnt_eff),
    .retire_err_o(retire_err),
    .req_hit_o   (req_hit),
    .dma_hit_o   (dma_hit)
  );
  always_comb begin
    load_ok = (!gv_q || grant_ready) && cnt_eff < CNT_BITS'(MAX_INFLIGHT);
    rst_el  = rst_tb_valid && cnt_eff == '0;
    req_el  = req_valid && !req_hit;
    dma_el  = dma_valid && !dma_hit;
    any_el  = rst_el || rsp_valid || req_el || dma_el;
    win     = rst_el ? ARB_RST : rsp_valid ? ARB_RSP :
              (req_el && dma_el) ? (rr_q ? ARB_DMA : ARB_REQ) :
              req_el ? ARB_REQ : ARB_DMA;
    win_set = win == ARB_RSP ? rsp_set : win == ARB_REQ ? req_set :
              win == ARB_DMA ? dma_set : '0;
    acc          = !rst && load_ok && any_el;
    rst_tb_ready = acc && win == ARB_RST;
    rsp_ready    = acc && win == ARB_RSP;
    req_ready    = acc && win == ARB_REQ;
    dma_ready    = acc && win == ARB_DMA;
    rr_d = rr_q ^ (acc && (win inside {ARB_REQ, ARB_DMA}) && req_el && dma_el);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      gv_q  <= 1'b0;
      src_q <= ARB_RST;
      set_q <= '0;
      rr_q  <= 1'b0;
    end else begin
      rr_q <= rr_d;
      if (acc) begin
        gv_q  <= 1'b1;
        src_q <= win;
        set_q <= win_set;
      end else if (grant_ready) begin
        gv_q <= 1'b0;
      end
    end
  end
  assign grant_valid = gv_q;
  assign grant_src   = src_q;
  assign grant_set   = set_q;
`ifdef LLC_ARB_STATS_EN
  logic [31:0] gcnt_q [4];
  logic [31:0] hz_q;
  logic        hz_stall;
  assign hz_stall = (req_valid && req_hit) || (dma_valid && dma_hit);
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) gcnt_q[i] <= '0;
      hz_q <= '0;
    end else begin
      if (acc && gcnt_q[win] != '1) gcnt_q[win] <= gcnt_q[win] + 1'b1;
      if (hz_stall && hz_q != '1) hz_q <= hz_q + 1'b1;
    end
  end
  assign stats_data = !stats_sel[2] ? gcnt_q[stats_sel[1:0]] : stats_sel == 3'd4 ? hz_q : '0;
`endif
endmodule

// File: tb/tb_llc_input_arbiter.sv
// tb_llc_input_arbiter: directed self-checking bench for llc_input_arbiter.
module tb_llc_input_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       rst_tb_valid, rst_tb_ready;
  logic       rsp_valid, rsp_ready;
  logic [8:0] rsp_set;
  logic       req_valid, req_ready;
  logic [8:0] req_set;
  logic       dma_valid, dma_ready;
  logic [8:0] dma_set;
  logic       grant_valid, grant_ready;
  logic [1:0] grant_src;
  logic [8:0] grant_set;
  logic       retire_valid;
  logic [2:0] inflight_cnt;
  logic       retire_err;
  int         tests = 0;
  int         fails = 0;
  always #5 clk = ~clk;
  llc_input_arbiter dut (
    .clk(clk), .rst(rst),
    .rst_tb_valid(rst_tb_valid), .rst_tb_ready(rst_tb_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_set(rsp_set),
    .req_valid(req_valid), .req_ready(req_ready), .req_set(req_set),
    .dma_valid(dma_valid), .dma_ready(dma_ready), .dma_set(dma_set),
    .grant_valid(grant_valid), .grant_ready(grant_ready),
    .grant_src(grant_src), .grant_set(grant_set),
    .retire_valid(retire_valid), .inflight_cnt(inflight_cnt), .retire_err(retire_err)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
    tests++;
    if (o !== e) begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", t, o, e);
    end
  endtask
  initial begin
    rst = 1'b1; rst_tb_valid = 0; rsp_valid = 0; rsp_set = 0; req_valid = 1; req_set = 9'd5;
    dma_valid = 0; dma_set = 0; grant_ready = 0; retire_valid = 0;
    tick(); tick();
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_gv", grant_valid, 1'b0);
    chk("rst_src", grant_src, 2'd0);
    chk("rst_set", grant_set, 9'd0);
    chk("rst_cnt", inflight_cnt, 3'd0);
    chk("rst_err", retire_err, 1'b0);
    rst = 0; grant_ready = 1; #1;
    chk("t1_req_ready", req_ready, 1'b1);
    tick(); req_valid = 0;
    chk("t1_gv", grant_valid, 1'b1);
    chk("t1_src", grant_src, 2'd2);
    chk("t1_set", grant_set, 9'd5);
    chk("t1_cnt", inflight_cnt, 3'd1);
    retire_valid = 1; tick(); retire_valid = 0;
    chk("t1_cnt_ret", inflight_cnt, 3'd0);
    chk("t1_gv_drop", grant_valid, 1'b0);
    rsp_valid = 1; rsp_set = 9'd3; req_valid = 1; req_set = 9'd10; dma_valid = 1; dma_set = 9'd11; #1;
    chk("t2_rsp_ready", rsp_ready, 1'b1);
    chk("t2_req_blk", req_ready, 1'b0);
    chk("t2_dma_blk", dma_ready, 1'b0);
    tick(); rsp_valid = 0; #1;
    chk("t2_src_rsp", grant_src, 2'd1);
    chk("t2_set_rsp", grant_set, 9'd3);
    chk("t2_rr_req", req_ready, 1'b1);
    chk("t2_rr_dma0", dma_ready, 1'b0);
    tick(); req_set = 9'd12; #1;
    chk("t2_src_req", grant_src, 2'd2);
    chk("t2_set_req", grant_set, 9'd10);
    chk("t2_rr_dma", dma_ready, 1'b1);
    chk("t2_rr_req0", req_ready, 1'b0);
    tick(); dma_set = 9'd13; retire_valid = 1; #1;
    chk("t2_src_dma", grant_src, 2'd3);
    chk("t2_set_dma", grant_set, 9'd11);
    chk("t2_cnt3", inflight_cnt, 3'd3);
    chk("t2_rr_req2", req_ready, 1'b1);
    tick(); req_set = 9'd14; #1;
    chk("t2_set_req2", grant_set, 9'd12);
    chk("t2_cnt_hold", inflight_cnt, 3'd3);
    chk("t2_rr_dma2", dma_ready, 1'b1);
    tick(); req_valid = 0; dma_valid = 0;
    chk("t2_set_dma2", grant_set, 9'd13);
    tick(); tick(); tick(); retire_valid = 0;
    chk("t2_drain", inflight_cnt, 3'd0);
    chk("t2_gv_idle", grant_valid, 1'b0);
    req_valid = 1; req_set = 9'd7; #1;
    chk("t3_req_ready", req_ready, 1'b1);
    tick(); req_valid = 0; dma_valid = 1; dma_set = 9'd7; #1;
    chk("t3_hazard", dma_ready, 1'b0);
    chk("t3_cnt", inflight_cnt, 3'd1);
    tick();
    chk("t3_hazard_hold", dma_ready, 1'b0);
    retire_valid = 1; #1;
    chk("t3_retire_free", dma_ready, 1'b1);
    tick(); retire_valid = 0; dma_valid = 0;
    chk("t3_src", grant_src, 2'd3);
    chk("t3_set", grant_set, 9'd7);
    chk("t3_cnt_swap", inflight_cnt, 3'd1);
    retire_valid = 1; tick(); retire_valid = 0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1; req_set = 9'(20 + i); #1;
      chk("t4_fill_ready", req_ready, 1'b1);
      tick();
    end
    req_set = 9'd24; rsp_valid = 1; #1;
    chk("t4_full_cnt", inflight_cnt, 3'd4);
    chk("t4_full_req", req_ready, 1'b0);
    chk("t4_full_rsp", rsp_ready, 1'b0);
    chk("t4_full_gv", grant_valid, 1'b1);
    rsp_valid = 0; retire_valid = 1; #1;
    chk("t4_swap_ready", req_ready, 1'b1);
    tick(); retire_valid = 0; req_valid = 0;
    chk("t4_swap_cnt", inflight_cnt, 3'd4);
    chk("t4_swap_set", grant_set, 9'd24);
    retire_valid = 1; tick(); tick(); tick(); tick(); retire_valid = 0;
    chk("t4_drain", inflight_cnt, 3'd0);
    req_valid = 1; req_set = 9'd30; tick(); req_valid = 0;
    dma_valid = 1; dma_set = 9'd31; tick(); dma_valid = 0;
    chk("t5_cnt2", inflight_cnt, 3'd2);
    rst_tb_valid = 1; #1;
    chk("t5_blk2", rst_tb_ready, 1'b0);
    retire_valid = 1; #1;
    chk("t5_blk1", rst_tb_ready, 1'b0);
    tick();
    chk("t5_cnt1", inflight_cnt, 3'd1);
    chk("t5_ready", rst_tb_ready, 1'b1);
    tick(); rst_tb_valid = 0; retire_valid = 0;
    chk("t5_gv", grant_valid, 1'b1);
    chk("t5_src", grant_src, 2'd0);
    chk("t5_set", grant_set, 9'd0);
    chk("t5_cnt_swap", inflight_cnt, 3'd1);
    retire_valid = 1; tick(); retire_valid = 0;
    chk("t5_drain", inflight_cnt, 3'd0);
    chk("t6_err_clean", retire_err, 1'b0);
    retire_valid = 1; tick(); retire_valid = 0;
    chk("t6_err", retire_err, 1'b1);
    chk("t6_cnt0", inflight_cnt, 3'd0);
    grant_ready = 0; req_valid = 1; req_set = 9'd40; tick();
    chk("t6_gv", grant_valid, 1'b1);
    chk("t6_err_sticky", retire_err, 1'b1);
    req_set = 9'd41; #1;
    chk("t6_stall_ready", req_ready, 1'b0);
    tick();
    chk("t6_hold_gv", grant_valid, 1'b1);
    chk("t6_hold_set", grant_set, 9'd40);
    req_valid = 0; rst = 1; tick(); rst = 0;
    chk("t6_rst_gv", grant_valid, 1'b0);
    chk("t6_rst_cnt", inflight_cnt, 3'd0);
    chk("t6_rst_err", retire_err, 1'b0);
    grant_ready = 1; req_valid = 1; req_set = 9'd40; #1;
    chk("t6_post_rst_ready", req_ready, 1'b1);
    tick(); req_valid = 0;
    chk("t6_post_rst_set", grant_set, 9'd40);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
